regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width.
REQ-002 The block SHALL have parameter CNT_W, default 2, per-register pending-counter width.
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1, synchronous active-low reset.
REQ-005 Port ra1, input, 5, read address port 1 (rs).
REQ-006 Port ra2, input, 5, read address port 2 (rt).
REQ-007 Port rd1, output, WIDTH, read data port 1.
REQ-008 Port rd2, output, WIDTH, read data port 2.
REQ-009 Port we3, input, 1, writeback enable.
REQ-010 Port wa3, input, 5, writeback address (output of the destination-register select mux).
REQ-011 Port wd3, input, WIDTH, writeback data.
REQ-012 Port issue_valid, input, 1, instruction issuing this cycle with a destination register.
REQ-013 Port issue_rd, input, 5, destination of the issuing instruction.
REQ-014 Port use1 / use2, input, 1 each, issuing instruction reads ra1 / ra2.
REQ-015 Port flush, input, 1, discard all pending-write tracking.
REQ-016 Port stall, output, 1, RAW hazard on an in-use source operand.
REQ-017 Port issue_ready, output, 1, issue_rd counter not saturated.
REQ-018 Port pend_err, output, 1, sticky flag: writeback to a register with zero pending count.

Function
REQ-019 Storage SHALL be 32 registers of WIDTH bits; register 0 SHALL read 0 and ignore writes.
REQ-020 On a rising edge with we3=1 and wa3!=0, rf[wa3] SHALL take wd3; reads SHALL be combinational, zero latency.
REQ-021 Each register 1..31 SHALL own a CNT_W-bit pending counter; register 0 SHALL never be pending.
REQ-022 issue_valid=1 and issue_rd!=0 and issue_ready=1 SHALL increment cnt[issue_rd]; issue_valid while issue_ready=0 SHALL leave state unchanged.
REQ-023 we3=1 and wa3!=0 SHALL decrement cnt[wa3] when nonzero; when zero, counter SHALL stay 0 and pend_err SHALL set.
REQ-024 Simultaneous accepted increment and decrement of the same register SHALL leave its counter unchanged.
REQ-025 issue_ready SHALL be 0 exactly when cnt[issue_rd] equals 2^CNT_W-1 and issue_rd!=0.
REQ-026 stall SHALL equal (use1 and cnt[ra1]!=0) or (use2 and cnt[ra2]!=0), combinational.
REQ-027 flush=1 SHALL clear all counters at the edge, overriding same-cycle issue and writeback counter updates; the data write of REQ-020 SHALL still occur.
REQ-028 Writebacks arriving after a flush SHALL hit zero counters without setting pend_err while a post-flush drain window (one clock after flush) is open.

Reset
REQ-029 reset_n=0 at a rising edge SHALL clear all 31 registers, all counters and pend_err; reset SHALL override write, issue and flush.
REQ-030 After reset: rd1=rd2=0, stall=0, issue_ready=1, pend_err=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight tracking with no partial update.

Configuration
REQ-032 Macro REGFILE_SB_BYPASS_EN defined: if we3=1, wa3!=0, wa3==raN, then rdN SHALL equal wd3, and that source SHALL not stall when cnt[raN]==1.
REQ-033 Macro undefined: reads SHALL return stored contents only; write data is visible the cycle after the write edge, and stall uses counters only.

Structure
REQ-034 Package mips32_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=0 and the register-address typedef.
REQ-035 The counter array and stall/ready logic SHALL form sub-module regfile_scoreboard, instantiated once.

Verification
REQ-036 Reset, then write wa3=5 wd3=0xDEADBEEF, read ra1=5 next cycle -> rd1=0xDEADBEEF; write wa3=0 wd3=0x1 -> rd1(ra1=0)=0.
REQ-037 Issue rd=8, next cycle use1=1 ra1=8 -> stall=1; writeback wa3=8 -> with BYPASS_EN stall=0 same cycle, without it stall=0 the cycle after.
REQ-038 Issue rd=9 three times, no writeback -> issue_ready=0 for issue_rd=9; the fourth issue is ignored; one writeback -> issue_ready=1.
REQ-039 With cnt[4]=1, issue rd=4 and writeback wa3=4 in the same cycle -> cnt[4] stays 1, stall persists for ra1=4.
REQ-040 Writeback wa3=12 with cnt[12]=0 and no flush -> pend_err=1 and it stays 1 until reset.
REQ-041 Issue rd=3 and rd=7, assert flush -> stall=0 for ra1=3, ra2=7; then reset_n=0 for one edge -> all registers read 0.

Source files
------------

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared register-file constants and address type
package mips32_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = reg_addr_t'(0);
endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/writeback/issue bus for the scoreboarded register file
interface regfile_sb_if #(
  parameter int WIDTH = 32
);
  import mips32_pkg::*;

  reg_addr_t        ra1;
  reg_addr_t        ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             we3;
  reg_addr_t        wa3;
  logic [WIDTH-1:0] wd3;
  logic             issue_valid;
  reg_addr_t        issue_rd;
  logic             use1;
  logic             use2;
  logic             flush;
  logic             stall;
  logic             issue_ready;
  logic             pend_err;

  modport master (
    output ra1, ra2, we3, wa3, wd3, issue_valid, issue_rd, use1, use2, flush,
    input  rd1, rd2, stall, issue_ready, pend_err
  );

  modport slave (
    input  ra1, ra2, we3, wa3, wd3, issue_valid, issue_rd, use1, use2, flush,
    output rd1, rd2, stall, issue_ready, pend_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write counters, stall and issue-ready logic
// Optional: REGFILE_SB_BYPASS_EN lets a matching writeback clear a last-pending stall.
module regfile_scoreboard
  import mips32_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_issue_valid,
  input  reg_addr_t i_issue_rd,
  input  logic      i_we3,
  input  reg_addr_t i_wa3,
  input  logic      i_flush,
  input  reg_addr_t i_ra1,
  input  reg_addr_t i_ra2,
  input  logic      i_use1,
  input  logic      i_use2,
  output logic      o_stall,
  output logic      o_issue_ready,
  output logic      o_pend_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic             r_pend_err;
  logic             r_drain;

  logic             w_inc;
  logic             w_dec;
  logic             w_same;
  logic [CNT_W-1:0] w_c1;
  logic [CNT_W-1:0] w_c2;
  logic [CNT_W-1:0] w_cw;
  logic             w_byp1;
  logic             w_byp2;

  assign w_c1 = r_cnt[i_ra1];
  assign w_c2 = r_cnt[i_ra2];
  assign w_cw = r_cnt[i_wa3];

  assign o_issue_ready = !((i_issue_rd != ZERO_REG) && (r_cnt[i_issue_rd] == CNT_MAX));
  assign w_inc  = i_issue_valid && (i_issue_rd != ZERO_REG) && o_issue_ready;
  assign w_dec  = i_we3 && (i_wa3 != ZERO_REG);
  assign w_same = w_inc && w_dec && (i_issue_rd == i_wa3);

`ifdef REGFILE_SB_BYPASS_EN
  assign w_byp1 = w_dec && (i_wa3 == i_ra1) && (w_c1 == CNT_ONE);
  assign w_byp2 = w_dec && (i_wa3 == i_ra2) && (w_c2 == CNT_ONE);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign o_stall = (i_use1 && (w_c1 != CNT_ZERO) && !w_byp1)
                || (i_use2 && (w_c2 != CNT_ZERO) && !w_byp2);
  assign o_pend_err = r_pend_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= CNT_ZERO;
      r_pend_err <= 1'b0;
      r_drain    <= 1'b0;
    end else begin
      r_drain <= i_flush;
      if (i_flush) begin
        for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= CNT_ZERO;
      end else if (!w_same) begin
        if (w_inc) r_cnt[i_issue_rd] <= r_cnt[i_issue_rd] + CNT_ONE;
        if (w_dec && (w_cw != CNT_ZERO)) r_cnt[i_wa3] <= w_cw - CNT_ONE;
        // Writebacks of instructions killed by the flush may still land once.
        if (w_dec && (w_cw == CNT_ZERO) && !r_drain) r_pend_err <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 32-entry two-read one-write register file with RAW scoreboard
// Optional: REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb
  import mips32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);
  logic [WIDTH-1:0] r_rf [NUM_REGS];
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic             w_wr;

  assign w_wr = bus.we3 && (bus.wa3 != ZERO_REG);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (w_wr) begin
      r_rf[bus.wa3] <= bus.wd3;
    end
  end

  always_comb begin
    w_rd1 = (bus.ra1 == ZERO_REG) ? '0 : r_rf[bus.ra1];
    w_rd2 = (bus.ra2 == ZERO_REG) ? '0 : r_rf[bus.ra2];
`ifdef REGFILE_SB_BYPASS_EN
    if (w_wr && (bus.wa3 == bus.ra1)) w_rd1 = bus.wd3;
    if (w_wr && (bus.wa3 == bus.ra2)) w_rd2 = bus.wd3;
`endif
  end

  assign bus.rd1 = w_rd1;
  assign bus.rd2 = w_rd2;

  regfile_scoreboard #(
    .CNT_W (CNT_W)
  ) u_sb (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_issue_valid (bus.issue_valid),
    .i_issue_rd    (bus.issue_rd),
    .i_we3         (bus.we3),
    .i_wa3         (bus.wa3),
    .i_flush       (bus.flush),
    .i_ra1         (bus.ra1),
    .i_ra2         (bus.ra2),
    .i_use1        (bus.use1),
    .i_use2        (bus.use2),
    .o_stall       (bus.stall),
    .o_issue_ready (bus.issue_ready),
    .o_pend_err    (bus.pend_err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb with a behavioural model
module tb_regfile_sb;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(WIDTH)) bus ();

  regfile_sb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_cnt [32];
  logic [31:0] m_rf  [32];
  bit          m_perr;
  bit          m_drain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && bus.we3 && bus.wa3 == a) return bus.wd3;
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input logic u);
    if (!u || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && bus.we3 && bus.wa3 == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic compare_all();
    chk("model_rd1", bus.rd1, exp_rd(bus.ra1));
    chk("model_rd2", bus.rd2, exp_rd(bus.ra2));
    chk("model_stall", {31'd0, bus.stall},
        {31'd0, exp_busy(bus.ra1, bus.use1) | exp_busy(bus.ra2, bus.use2)});
    chk("model_issue_ready", {31'd0, bus.issue_ready},
        {31'd0, !(bus.issue_rd != 5'd0 && m_cnt[bus.issue_rd] == CMAX)});
    chk("model_pend_err", {31'd0, bus.pend_err}, {31'd0, m_perr});
  endtask

  task automatic model_step();
    bit inc_ok, dec_ok, same;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_cnt[i] = 0;
        m_rf[i]  = 32'd0;
      end
      m_perr  = 1'b0;
      m_drain = 1'b0;
      return;
    end
    inc_ok = bus.issue_valid && bus.issue_rd != 5'd0 && m_cnt[bus.issue_rd] < CMAX;
    dec_ok = bus.we3 && bus.wa3 != 5'd0;
    same   = inc_ok && dec_ok && bus.issue_rd == bus.wa3;
    if (dec_ok) m_rf[bus.wa3] = bus.wd3;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else if (!same) begin
      if (dec_ok && m_cnt[bus.wa3] == 0 && !m_drain) m_perr = 1'b1;
      if (dec_ok && m_cnt[bus.wa3] > 0) m_cnt[bus.wa3] = m_cnt[bus.wa3] - 1;
      if (inc_ok) m_cnt[bus.issue_rd] = m_cnt[bus.issue_rd] + 1;
    end
    m_drain = bus.flush;
  endtask

  task automatic idle();
    bus.ra1 = '0; bus.ra2 = '0; bus.we3 = 1'b0; bus.wa3 = '0; bus.wd3 = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.use1 = 1'b0; bus.use2 = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = rd; tick();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    idle(); bus.we3 = 1'b1; bus.wa3 = a; bus.wd3 = d; tick();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    #1;
    reset_n = 1'b1;

    // Reset state
    idle(); bus.ra1 = 5'd1; bus.ra2 = 5'd2; bus.use1 = 1'b1; bus.use2 = 1'b1; bus.issue_rd = 5'd5;
    #1;
    chk("rst_rd1", bus.rd1, 32'd0);
    chk("rst_rd2", bus.rd2, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    chk("rst_pend_err", {31'd0, bus.pend_err}, 32'd0);
    tick();

    // Write/read and register 0
    issue(5'd5);
    wb(5'd5, 32'hDEADBEEF);
    idle(); bus.ra1 = 5'd5; #1;
    chk("rd1_r5", bus.rd1, 32'hDEADBEEF);
    tick();
    wb(5'd0, 32'h1);
    idle(); #1;
    chk("rd1_r0", bus.rd1, 32'd0);
    tick();

    // RAW stall released by writeback
    issue(5'd8);
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd8; #1;
    chk("stall_r8", {31'd0, bus.stall}, 32'd1);
    tick();
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd8; bus.we3 = 1'b1; bus.wa3 = 5'd8; bus.wd3 = 32'h88; #1;
    chk("stall_r8_wb", {31'd0, bus.stall}, BYP ? 32'd0 : 32'd1);
    tick();
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd8; #1;
    chk("stall_r8_after", {31'd0, bus.stall}, 32'd0);
    chk("rd1_r8", bus.rd1, 32'h88);
    tick();

    // Counter saturation
    repeat (3) issue(5'd9);
    idle(); bus.issue_rd = 5'd9; #1;
    chk("ready_r9_sat", {31'd0, bus.issue_ready}, 32'd0);
    tick();
    issue(5'd9);
    wb(5'd9, 32'h9);
    idle(); bus.issue_rd = 5'd9; #1;
    chk("ready_r9_after_wb", {31'd0, bus.issue_ready}, 32'd1);
    tick();

    // Simultaneous issue and writeback of the same register
    issue(5'd4);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    bus.we3 = 1'b1; bus.wa3 = 5'd4; bus.wd3 = 32'h44; bus.use1 = 1'b1; bus.ra1 = 5'd4;
    tick();
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd4; #1;
    chk("stall_r4_persist", {31'd0, bus.stall}, 32'd1);
    tick();
    wb(5'd4, 32'h45);
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd4; #1;
    chk("stall_r4_clear", {31'd0, bus.stall}, 32'd0);
    tick();

    // Flush and post-flush drain window
    issue(5'd3);
    issue(5'd7);
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd3; bus.use2 = 1'b1; bus.ra2 = 5'd7; #1;
    chk("stall_pre_flush", {31'd0, bus.stall}, 32'd1);
    tick();
    idle(); bus.flush = 1'b1; bus.we3 = 1'b1; bus.wa3 = 5'd9; bus.wd3 = 32'h99;
    tick();
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd3; bus.use2 = 1'b1; bus.ra2 = 5'd7;
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 32'h33; #1;
    chk("stall_post_flush", {31'd0, bus.stall}, 32'd0);
    tick();
    idle(); bus.ra1 = 5'd9; #1;
    chk("drain_no_pend_err", {31'd0, bus.pend_err}, 32'd0);
    chk("rd1_r9_flush_write", bus.rd1, 32'h99);
    tick();

    // Sticky pending-count error
    wb(5'd12, 32'hC);
    idle(); #1;
    chk("pend_err_set", {31'd0, bus.pend_err}, 32'd1);
    tick();
    repeat (3) tick();
    chk("pend_err_sticky", {31'd0, bus.pend_err}, 32'd1);

    // Mid-operation reset overrides write and issue
    issue(5'd6);
    idle(); reset_n = 1'b0; bus.we3 = 1'b1; bus.wa3 = 5'd5; bus.wd3 = 32'h1234;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle(); bus.ra1 = 5'(i); bus.ra2 = 5'(i + 16); bus.use1 = 1'b1; bus.issue_rd = 5'd6; #1;
      chk("post_rst_rd1", bus.rd1, 32'd0);
      chk("post_rst_rd2", bus.rd2, 32'd0);
      tick();
    end
    idle(); bus.use1 = 1'b1; bus.ra1 = 5'd6; #1;
    chk("post_rst_stall_r6", {31'd0, bus.stall}, 32'd0);
    chk("post_rst_pend_err", {31'd0, bus.pend_err}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
